clock_alarm_core: RTL and testbench

- Parametrised RTL successor to the Qsys seconds-tick clock system.
- Divides clk_clk down to a 1 Hz tick and keeps BCD time HH:MM:SS (24 h).
- Supports loading the time and setting an HH:MM alarm with an enable, timed ring and stop.
- Drives six 8-bit seven-segment digit outputs plus a per-second pulse to the processor/IRQ fabric.

---
 rtl/clock_alarm_core.sv | 196 +++++++++++++++++++
 tb/tb_clock_alarm_core.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_alarm_core.sv
// 24 h BCD clock with 1 Hz prescaler, HH:MM alarm and seven-segment outputs.
// Optional snooze state enabled by defining CLOCK_ALARM_SNOOZE_EN.
module clock_alarm_core #(
    parameter int CLK_HZ         = 50000000,
    parameter int RING_SECS      = 60,
    parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef CLOCK_ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_SECS    = 300
`endif
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        set_time,
    input  logic [7:0]  set_hh,
    input  logic [7:0]  set_mm,
    input  logic [7:0]  set_ss,
    input  logic        set_alarm,
    input  logic        alarm_en,
    input  logic        alarm_stop,
`ifdef CLOCK_ALARM_SNOOZE_EN
    input  logic        snooze,
`endif
    output logic        set_err,
    output logic        tick_irq,
    output logic [23:0] time_bcd,
    output logic        alarm_ring,
    output logic [7:0]  seg_h1,
    output logic [7:0]  seg_h2,
    output logic [7:0]  seg_m1,
    output logic [7:0]  seg_m2,
    output logic [7:0]  seg_s1,
    output logic [7:0]  seg_s2
);

    localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PS_TOP  = PW'(CLK_HZ - 1);
    localparam logic [15:0]     RING_LD = 16'(RING_SECS);
`ifdef CLOCK_ALARM_SNOOZE_EN
    localparam logic [15:0]     SNZ_LD  = 16'(SNOOZE_SECS);
`endif
    localparam logic [7:0]      SEG0    = SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;

`ifdef CLOCK_ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RING} state_t;
`endif

    state_t        st_q, st_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] psc_q;
    logic [15:0]   alm_q;
    logic [23:0]   time_d;
    logic          tick, time_ok, alm_ok, load, tick_eff, trig;

    function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] lim);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= lim);
    endfunction

    // Digit-wise BCD increment with second/minute/hour carries.
    function automatic logic [23:0] bcd_tick(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
                else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
                    else begin
                        r[15:12] = 4'd0;
                        if (t[23:16] == 8'h23) r[23:16] = 8'h00;
                        else if (t[19:16] != 4'd9) r[19:16] = t[19:16] + 4'd1;
                        else begin
                            r[19:16] = 4'd0;
                            r[23:20] = t[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            default: p = 8'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    assign tick     = (psc_q == PS_TOP);
    assign time_ok  = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59)
                   && bcd_ok(set_ss, 8'h59);
    assign alm_ok   = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59);
    assign load     = set_time && time_ok;
    assign tick_eff = tick && !load;
    assign time_d   = load ? {set_hh, set_mm, set_ss}
                    : tick_eff ? bcd_tick(time_bcd) : time_bcd;
    assign trig     = tick_eff && alarm_en && (time_d == {alm_q, 8'h00});
    assign alarm_ring = (st_q == RING);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            psc_q    <= '0;
            time_bcd <= '0;
            alm_q    <= '0;
            tick_irq <= 1'b0;
            set_err  <= 1'b0;
            seg_h1   <= SEG0;
            seg_h2   <= SEG0;
            seg_m1   <= SEG0;
            seg_m2   <= SEG0;
            seg_s1   <= SEG0;
            seg_s2   <= SEG0;
        end else begin
            psc_q    <= (tick || load) ? '0 : psc_q + 1'b1;
            time_bcd <= time_d;
            tick_irq <= tick_eff;
            set_err  <= (set_time && !time_ok) || (set_alarm && !alm_ok);
            if (set_alarm && alm_ok) alm_q <= {set_hh, set_mm};
            seg_h1   <= seg_enc(time_bcd[23:20]);
            seg_h2   <= seg_enc(time_bcd[19:16]);
            seg_m1   <= seg_enc(time_bcd[15:12]);
            seg_m2   <= seg_enc(time_bcd[11:8]);
            seg_s1   <= seg_enc(time_bcd[7:4]);
            seg_s2   <= seg_enc(time_bcd[3:0]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Stop and disable take priority over every other event.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        unique case (st_q)
            IDLE: begin
                if (trig && !alarm_stop) begin
                    st_d  = RING;
                    cnt_d = RING_LD;
                end
            end
            RING: begin
                if (alarm_stop || !alarm_en) st_d = IDLE;
`ifdef CLOCK_ALARM_SNOOZE_EN
                else if (snooze) begin
                    st_d  = SNOOZE;
                    cnt_d = SNZ_LD;
                end
`endif
                else if (tick_eff) begin
                    if (cnt_q <= 16'd1) st_d = IDLE;
                    else cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef CLOCK_ALARM_SNOOZE_EN
            SNOOZE: begin
                if (alarm_stop || !alarm_en) st_d = IDLE;
                else if (tick_eff) begin
                    if (cnt_q <= 16'd1) begin
                        st_d  = RING;
                        cnt_d = RING_LD;
                    end else cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            default: st_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clock_alarm_core.sv
// Randomized plus directed bench for clock_alarm_core against a
// seconds-of-day reference model.
module tb_clock_alarm_core;

    localparam int CLK_HZ      = 10;
    localparam int RING_SECS   = 3;
    localparam int SNOOZE_SECS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_time, set_alarm, alarm_en, alarm_stop, snooze;
    logic [7:0]  set_hh, set_mm, set_ss;
    logic        set_err, tick_irq, alarm_ring;
    logic [23:0] time_bcd;
    logic [7:0]  seg_h1, seg_h2, seg_m1, seg_m2, seg_s1, seg_s2;

    always #5 clk = ~clk;

    clock_alarm_core #(
        .CLK_HZ(CLK_HZ),
        .RING_SECS(RING_SECS),
        .SEG_ACTIVE_LOW(1'b1)
`ifdef CLOCK_ALARM_SNOOZE_EN
        ,
        .SNOOZE_SECS(SNOOZE_SECS)
`endif
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .set_time(set_time),
        .set_hh(set_hh),
        .set_mm(set_mm),
        .set_ss(set_ss),
        .set_alarm(set_alarm),
        .alarm_en(alarm_en),
        .alarm_stop(alarm_stop),
`ifdef CLOCK_ALARM_SNOOZE_EN
        .snooze(snooze),
`endif
        .set_err(set_err),
        .tick_irq(tick_irq),
        .time_bcd(time_bcd),
        .alarm_ring(alarm_ring),
        .seg_h1(seg_h1),
        .seg_h2(seg_h2),
        .seg_m1(seg_m1),
        .seg_m2(seg_m2),
        .seg_s1(seg_s1),
        .seg_s2(seg_s2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: time as seconds of day, alarm as minute of day.
    int m_psc, m_sec, m_seg_sec, m_alm_min, m_mode, m_cnt;
    bit m_tick, m_err;
    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit b_ok(input logic [7:0] b, input int lim);
        return (b[7:4] <= 9) && (b[3:0] <= 9) && (b2i(b) <= lim);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        return {i2b(s / 3600), i2b((s / 60) % 60), i2b(s % 60)};
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        return ~seg_tab[d];
    endfunction

    function automatic logic [47:0] exp_segs(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10),
                seg_of(m % 10), seg_of(x / 10), seg_of(x % 10)};
    endfunction

    task automatic model_reset();
        m_psc = 0; m_sec = 0; m_seg_sec = 0; m_alm_min = 0;
        m_mode = 0; m_cnt = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit tick, tv, av, ld, teff, trig, snz;
        int nsec;
`ifdef CLOCK_ALARM_SNOOZE_EN
        snz = snooze;
`else
        snz = 1'b0;
`endif
        tick = (m_psc == CLK_HZ - 1);
        av   = b_ok(set_hh, 23) && b_ok(set_mm, 59);
        tv   = av && b_ok(set_ss, 59);
        ld   = set_time && tv;
        teff = tick && !ld;
        if (ld) nsec = b2i(set_hh) * 3600 + b2i(set_mm) * 60 + b2i(set_ss);
        else if (teff) nsec = (m_sec + 1) % 86400;
        else nsec = m_sec;
        trig = teff && alarm_en && (nsec == m_alm_min * 60);
        case (m_mode)
            0: if (trig && !alarm_stop) begin m_mode = 1; m_cnt = RING_SECS; end
            1: begin
                if (alarm_stop || !alarm_en) m_mode = 0;
                else if (snz) begin m_mode = 2; m_cnt = SNOOZE_SECS; end
                else if (teff) begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = 0;
                end
            end
            default: begin
                if (alarm_stop || !alarm_en) m_mode = 0;
                else if (teff) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_mode = 1; m_cnt = RING_SECS; end
                end
            end
        endcase
        m_psc     = (tick || ld) ? 0 : m_psc + 1;
        m_seg_sec = m_sec;
        m_sec     = nsec;
        m_tick    = teff;
        m_err     = (set_time && !tv) || (set_alarm && !av);
        if (set_alarm && av) m_alm_min = b2i(set_hh) * 60 + b2i(set_mm);
    endtask

    task automatic compare_all();
        check("time", time_bcd, to_bcd(m_sec));
        check("tick", tick_irq, m_tick);
        check("err", set_err, m_err);
        check("ring", alarm_ring, m_mode == 1);
        check("segs", {seg_h1, seg_h2, seg_m1, seg_m2, seg_s1, seg_s2},
              exp_segs(m_seg_sec));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        set_time = 0; set_alarm = 0; alarm_stop = 0; snooze = 0;
        set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_time(input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
        set_time = 1; set_hh = h; set_mm = m; set_ss = s;
        step();
    endtask

    task automatic load_alarm(input logic [7:0] h, input logic [7:0] m);
        set_alarm = 1; set_hh = h; set_mm = m; set_ss = 8'($urandom);
        step();
    endtask

    initial begin
        int n, s;
        bit seen;
        set_time = 0; set_alarm = 0; alarm_stop = 0; snooze = 0;
        alarm_en = 0; set_hh = 0; set_mm = 0; set_ss = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_seg_h1", seg_h1, 8'hC0);
        rst_n = 1;

        for (int i = 1; i <= 35; i++) begin
            step();
            if (i == 10 || i == 20 || i == 30) check("tick_at", tick_irq, 1);
        end
        check("t35", time_bcd, 24'h000003);
        check("t35_seg_s2", seg_s2, 8'hB0);

        load_time(8'h23, 8'h59, 8'h59);
        steps(11);
        check("wrap", time_bcd, 24'h000000);
        check("wrap_seg_h1", seg_h1, 8'hC0);

        load_time(8'h24, 8'h00, 8'h00);
        check("bad_hh", set_err, 1);
        step();
        check("err_pulse", set_err, 0);
        load_time(8'h10, 8'h5A, 8'h00);
        check("bad_mm", set_err, 1);

        alarm_en = 1;
        load_alarm(8'h07, 8'h30);
        load_time(8'h07, 8'h29, 8'h59);
        steps(10);
        check("ring_on", alarm_ring, 1);
        steps(29);
        check("ring_hold", alarm_ring, 1);
        step();
        check("ring_auto_off", alarm_ring, 0);

        load_time(8'h07, 8'h29, 8'h59);
        steps(10);
        check("ring_on2", alarm_ring, 1);
        steps(5);
        alarm_stop = 1;
        step();
        check("ring_stop", alarm_ring, 0);

        n = 0;
        while (m_psc != CLK_HZ - 1 && n < 20) begin step(); n++; end
        load_time(8'h12, 8'h34, 8'h56);
        check("term_no_tick", tick_irq, 0);
        check("term_load", time_bcd, 24'h123456);
        n = 0;
        seen = 0;
        while (!seen && n < 3 * CLK_HZ) begin
            step();
            n++;
            seen = tick_irq;
        end
        check("term_next_tick", n, CLK_HZ);

`ifdef CLOCK_ALARM_SNOOZE_EN
        load_time(8'h07, 8'h29, 8'h59);
        steps(10);
        check("snz_ring", alarm_ring, 1);
        snooze = 1;
        step();
        check("snz_quiet", alarm_ring, 0);
        n = 0;
        s = 0;
        while (s < 2 && n < 6 * CLK_HZ) begin
            step();
            n++;
            if (tick_irq) s++;
        end
        check("snz_ticks", s, 2);
        check("snz_rering", alarm_ring, 1);
        alarm_stop = 1;
        step();
        check("snz_stop", alarm_ring, 0);
`endif

        load_time(8'h07, 8'h29, 8'h59);
        steps(10);
        check("pre_rst_ring", alarm_ring, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_ring", alarm_ring, 0);
        check("async_time", time_bcd, 24'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all();

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_hh = 8'($urandom); set_mm = 8'($urandom);
                    set_ss = 8'($urandom);
                end else begin
                    s = (m_alm_min * 60 + 86400 - $urandom_range(1, 8)) % 86400;
                    {set_hh, set_mm, set_ss} = to_bcd(s);
                end
                set_time = 1;
            end
            if ($urandom_range(0, 99) < 1) begin
                if (!set_time) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_hh = 8'($urandom); set_mm = 8'($urandom);
                    end else begin
                        set_hh = i2b($urandom_range(0, 23));
                        set_mm = i2b($urandom_range(0, 59));
                    end
                end
                set_alarm = 1;
            end
            if ($urandom_range(0, 199) < 2) alarm_stop = 1;
            if ($urandom_range(0, 199) < 4) snooze = 1;
            if ($urandom_range(0, 399) < 2) alarm_en = ~alarm_en;
            if ($urandom_range(0, 99) < 5) alarm_en = 1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
